// File: rtl/z80_bus_pkg.sv
// Shared encodings for the Z80 bus responder.
//   - sel values driven on pins_ui[7:6] to pick the uo_out multiplex group
//   - bit indices of the captured control byte {busak,halt,rfsh,wr,rd,iorq,mreq,m1}_n
//   - scan FSM state type
//   - bit positions inside pins_ui
package z80_bus_pkg;

  localparam logic [1:0] SEL_ALO  = 2'b00;
  localparam logic [1:0] SEL_AHI  = 2'b01;
  localparam logic [1:0] SEL_CTRL = 2'b10;

  localparam int M1    = 0;
  localparam int MREQ  = 1;
  localparam int IORQ  = 2;
  localparam int RD    = 3;
  localparam int WR    = 4;
  localparam int RFSH  = 5;
  localparam int HALT  = 6;
  localparam int BUSAK = 7;

  // Each state names the action taken at the end of the fast cycle spent in it.
  typedef enum logic [2:0] {
    S_SEL_CTRL,
    S_CAP_CTRL,
    S_CAP_ALO,
    S_CAP_AHI,
    S_IDLE
  } scan_t;

  localparam int UI_WAIT  = 0;
  localparam int UI_INT   = 1;
  localparam int UI_NMI   = 2;
  localparam int UI_BUSRQ = 3;
  localparam int UI_EARLY = 4;
  localparam int UI_SEL   = 6;

endpackage

// File: rtl/z80_resp_ram.sv
// Responder RAM: one write port shared by host preload and CPU writes
// (host wins on collision), asynchronous read. Contents are not reset.
//   clk                           fast clock
//   host_we/host_addr/host_wdata  preload write
//   cpu_we/cpu_addr/cpu_wdata     CPU memory write
//   raddr/rdata                   asynchronous read
module z80_resp_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (host_we)     mem[host_addr] <= host_wdata;
    else if (cpu_we) mem[cpu_addr]  <= cpu_wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/z80_bus_responder.sv
// Memory/IO system on the far side of the TinyTapeout Z80 pin interface.
// Generates the Z80 clock and reset, scans the multiplexed uo_out pins into
// control/address registers once per Z80 half-period, and answers memory,
// I/O and interrupt-acknowledge cycles.
//   clk, rst_n          fast clock, async active-low reset
//   pins_uo             CPU uo_out (ctrl / A[7:0] / A[15:8] by sel)
//   pins_uio_in/_oe     CPU data out and its enable (bit 0 only)
//   pins_ui             {sel[1:0], EARLY, busrq_n, nmi_n, int_n, wait_n}
//   pins_uio_out        data to CPU
//   z80_clk, z80_rst_n  CPU clock and reset
//   irq                 active-high interrupt request
//   io_in               I/O read data
//   io_out/io_addr      I/O write data and port, io_strobe one-clk pulse
//   host_we/addr/wdata  RAM preload
// Optional feature: define Z80_RESP_WAIT_EN to insert WAIT_STATES wait
// cycles on each memory read; otherwise wait_n is tied high.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         HALF        = 4,
  parameter int         MEM_AW      = 8,
  parameter logic [7:0] INT_VECTOR  = 8'hFF,
  parameter logic [1:0] EARLY       = 2'b00,
  parameter int         RST_CYCLES  = 4,
  parameter int         WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pins_uo,
  input  logic [7:0]        pins_uio_in,
  input  logic [7:0]        pins_uio_oe,
  output logic [7:0]        pins_ui,
  output logic [7:0]        pins_uio_out,
  output logic              z80_clk,
  output logic              z80_rst_n,
  input  logic              irq,
  input  logic [7:0]        io_in,
  output logic [7:0]        io_out,
  output logic [7:0]        io_addr,
  output logic              io_strobe,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata
);

  localparam int CW = $clog2(HALF);
  localparam int RW = $clog2(RST_CYCLES + 1);

  // ---------------- clock generation ----------------
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wrap;

  assign wrap    = (cnt == CW'(HALF - 1));
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      z80_clk <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) z80_clk <= ~z80_clk;
    end
  end

  // ---------------- CPU reset ----------------
  logic [RW-1:0] rcnt;

  // Counts z80_clk rising edges (a wrap while z80_clk is low), saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt      <= '0;
      z80_rst_n <= 1'b0;
    end else begin
      if (wrap && !z80_clk && rcnt != RW'(RST_CYCLES)) rcnt <= rcnt + 1'b1;
      if (rcnt == RW'(RST_CYCLES)) z80_rst_n <= 1'b1;
    end
  end

  // ---------------- scan FSM ----------------
  // The state is derived one cycle ahead from the counter, so each slot's
  // action lands on the edge where the counter enters that slot. This leaves
  // HALF-3 fast cycles between decode and the next z80_clk edge.
  scan_t      scan, scan_nxt;
  logic [1:0] sel, sel_nxt;
  logic       cap_ctrl, cap_alo, cap_ahi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan <= S_CAP_CTRL;
    else        scan <= scan_nxt;
  end

  always_comb begin
    scan_nxt = S_IDLE;
    if (cnt_nxt == CW'(HALF - 1)) scan_nxt = S_SEL_CTRL;
    else if (cnt_nxt == CW'(0))   scan_nxt = S_CAP_CTRL;
    else if (cnt_nxt == CW'(1))   scan_nxt = S_CAP_ALO;
    else if (cnt_nxt == CW'(2))   scan_nxt = S_CAP_AHI;

    sel_nxt  = sel;
    cap_ctrl = 1'b0;
    cap_alo  = 1'b0;
    cap_ahi  = 1'b0;
    case (scan)
      S_SEL_CTRL: sel_nxt = SEL_CTRL;
      S_CAP_CTRL: begin cap_ctrl = 1'b1; sel_nxt = SEL_ALO;  end
      S_CAP_ALO:  begin cap_alo  = 1'b1; sel_nxt = SEL_AHI;  end
      S_CAP_AHI:  begin cap_ahi  = 1'b1; sel_nxt = SEL_CTRL; end
      default: ;
    endcase
  end

  // ---------------- capture and decode ----------------
  logic [7:0]  ctrl, ctrl_prev, dat, a_lo, a_hi;
  logic        oe;
  logic [15:0] addr_now;
  logic [7:0]  ram_rdata, rd_val;
  logic        rd_dec, mem_wr, io_wr, mem_rd_first;
  logic        int_n, wait_n;

  // A[15:8] is on the pins during the decode edge itself.
  assign addr_now = {pins_uo, a_lo};

  // First-half-period qualifiers look at the previous slot-1 sample so a
  // write held across several half-periods acts once.
  always_comb begin
    rd_dec       = 1'b0;
    rd_val       = pins_uio_out;
    mem_wr       = 1'b0;
    io_wr        = 1'b0;
    mem_rd_first = 1'b0;
    if (ctrl[RFSH]) begin
      if (!ctrl[M1] && !ctrl[IORQ]) begin
        rd_dec = 1'b1;
        rd_val = INT_VECTOR;
      end else if (!ctrl[MREQ] && !ctrl[RD]) begin
        rd_dec       = 1'b1;
        rd_val       = ram_rdata;
        mem_rd_first = ctrl_prev[MREQ] | ctrl_prev[RD];
      end else if (!ctrl[MREQ] && !ctrl[WR] && oe) begin
        mem_wr = ctrl_prev[WR];
      end else if (!ctrl[IORQ] && !ctrl[RD]) begin
        rd_dec = 1'b1;
        rd_val = io_in;
      end else if (!ctrl[IORQ] && !ctrl[WR] && oe) begin
        io_wr = ctrl_prev[WR];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel          <= SEL_CTRL;
      ctrl         <= '0;
      ctrl_prev    <= '1;
      dat          <= '0;
      oe           <= 1'b0;
      a_lo         <= '0;
      a_hi         <= '0;
      pins_uio_out <= '0;
      io_out       <= '0;
      io_addr      <= '0;
      io_strobe    <= 1'b0;
      int_n        <= 1'b1;
    end else begin
      sel       <= sel_nxt;
      io_strobe <= 1'b0;
      if (cap_ctrl) begin
        ctrl_prev <= ctrl;
        ctrl      <= pins_uo;
        dat       <= pins_uio_in;
        oe        <= pins_uio_oe[0];
      end
      if (cap_alo) a_lo <= pins_uo;
      if (cap_ahi) begin
        a_hi  <= pins_uo;
        int_n <= ~irq;
        if (rd_dec) pins_uio_out <= rd_val;
        if (io_wr) begin
          io_out    <= dat;
          io_addr   <= a_lo;
          io_strobe <= 1'b1;
        end
      end
    end
  end

  z80_resp_ram #(.AW(MEM_AW)) u_ram (
    .clk        (clk),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .cpu_we     (cap_ahi & mem_wr),
    .cpu_addr   (addr_now[MEM_AW-1:0]),
    .cpu_wdata  (dat),
    .raddr      (addr_now[MEM_AW-1:0]),
    .rdata      (ram_rdata)
  );

  // ---------------- wait states ----------------
`ifdef Z80_RESP_WAIT_EN
  localparam int WW = $clog2(2 * WAIT_STATES + 1);
  logic [WW-1:0] wcnt;

  // Counts remaining half-periods of wait, ticking at each decode slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      wait_n <= 1'b1;
    end else if (cap_ahi) begin
      if (wcnt == WW'(1)) begin
        wcnt   <= '0;
        wait_n <= 1'b1;
      end else if (wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end else if (mem_rd_first) begin
        wcnt   <= WW'(2 * WAIT_STATES);
        wait_n <= 1'b0;
      end
    end
  end
`else
  assign wait_n = 1'b1;
  logic unused_wait;
  assign unused_wait = mem_rd_first;
`endif

  // ---------------- pins_ui ----------------
  always_comb begin
    pins_ui                  = '0;
    pins_ui[UI_SEL +: 2]     = sel;
    pins_ui[UI_EARLY +: 2]   = EARLY;
    pins_ui[UI_BUSRQ]        = 1'b1;
    pins_ui[UI_NMI]          = 1'b1;
    pins_ui[UI_INT]          = int_n;
    pins_ui[UI_WAIT]         = wait_n;
  end

  // Captured but not consumed by any decode path.
  logic unused_ok;
  assign unused_ok = &{1'b0, a_hi, addr_now, ctrl, ctrl_prev, pins_uio_oe[7:1]};

endmodule
